convpress_node_seq: RTL and testbench
=====================================

Name: convpress_node_seq

Overview:
- Sequencer for one convpress node datapath (NBin/offset SRAM, NBout, N0 multiplier array, N1 adder/accumulator, N2 sigmoid).
- For each output row, it does four things in order:
  - restores the partial sum from NBout, or clears the accumulator;
  - streams the input-block addresses to NBin and requests SB data;
  - tracks pipeline occupancy;
  - writes the result back to NBout, as the raw partial sum or the sigmoid output.
- Sits beside the node top and drives its control inputs. Configured per pass by the layer controller.

Parameters:
- ADDR_SZ, 6, width of NBin/NBout row addresses.
- CNT_SZ, 8, width of the input-block count.
- PIPE_LAT, 3, cycles from an accepted NBin address to the matching N1 result. Legal range is ≥1.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start a pass. Sampled only in IDLE.
- i_num_in  in  CNT_SZ  input blocks per output row. Latched at start.
- i_num_out  in  ADDR_SZ  output rows in the pass. Latched at start.
- i_first_pass  in  1  1 = clear the accumulator; 0 = reload the partial sum from NBout. Latched.
- i_last_pass  in  1  1 = write the sigmoid (N2) result; 0 = write the N1 partial sum. Latched.
- i_stall  in  1  SB/eDRAM data not ready this cycle.
- o_busy  out  1  high from the cycle after start is accepted until the cycle after DONE.
- o_done  out  1  one-cycle pulse at the end of the pass.
- o_nbin_addr  out  ADDR_SZ  NBin row to read.
- o_sb_req  out  1  issue request to SB.
- o_nbout_addr  out  ADDR_SZ  NBout row to read or write.
- o_nbout_wen  out  1  NBout write enable.
- o_load_nbout  out  1  select NBout data into the N1/N2 pipeline register.
- o_acc_clr  out  1  clear the N1/N2 pipeline register.
- o_acc_en  out  1  N1 result valid; the N1/N2 register updates on o_acc_en | o_load_nbout | o_acc_clr.
- o_n1_n2_to_nbout  out  1  NBout write source: 1 = N2, 0 = N1.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0, the valid shift register is cleared.
  - Reset mid-pass aborts the pass; no o_done is produced.
- States:
  - IDLE: wait for i_start. If i_num_in==0 or i_num_out==0, go to DONE; otherwise latch the config, clear out_idx, go to PRELOAD.
  - PRELOAD (1 cycle): o_nbout_addr=out_idx. NBout read latency is 1 cycle.
  - LOAD (1 cycle): pulse o_load_nbout if !first_pass, else pulse o_acc_clr. o_nbout_addr is held. Clear in_idx.
  - ISSUE: o_nbin_addr=in_idx, o_sb_req=1.
    - A cycle with !i_stall accepts the address: in_idx++ and a 1 is shifted into the valid shift register.
    - A stalled cycle shifts in a 0 and holds in_idx and o_nbin_addr.
    - After in_idx==num_in-1 is accepted, go to DRAIN.
  - DRAIN: o_sb_req=0. Wait until the valid shift register is all zero.
  - WRITE (1 cycle): o_nbout_addr=out_idx, o_nbout_wen=1, o_n1_n2_to_nbout=last_pass. Then:
    - if out_idx==num_out-1, go to DONE;
    - otherwise out_idx++ and go to PRELOAD.
  - DONE (1 cycle): o_done=1. Return to IDLE.
- Valid shift register: PIPE_LAT bits. o_acc_en is its oldest bit, so it goes high exactly PIPE_LAT cycles after an accepted issue. It shifts every cycle in every state.
- o_n1_n2_to_nbout is held at last_pass for the whole pass (the mux is static during a pass). It returns to 0 in IDLE.
- i_start while busy is ignored. Config inputs are ignored after latching.
- i_stall outside ISSUE is ignored.
- Counter widths: in_idx is CNT_SZ bits and out_idx is ADDR_SZ bits.
  - Comparisons are against count-1, so no wrap-around is possible.
  - The maximum counts (2^CNT_SZ-1 and 2^ADDR_SZ-1) are legal.
- Latency with no stalls: o_done is high in cycle k+1+num_out*(3+num_in+PIPE_LAT), where start is sampled at edge k.

Decomposition:
- Shared package convpress_pkg holds:
  - the state encoding constants (IDLE, PRELOAD, LOAD, ISSUE, DRAIN, WRITE, DONE);
  - the default ADDR_SZ, CNT_SZ and PIPE_LAT constants.
- One natural sub-module: convpress_valid_pipe, the PIPE_LAT-deep valid shift register with an all-zero flag.

Test Plan:
- num_out=2, num_in=4, first_pass=1, last_pass=0, no stall:
  - o_acc_clr pulses 2 times; o_nbin_addr goes 0,1,2,3 twice;
  - o_nbout_wen at addresses 0 then 1 with o_n1_n2_to_nbout=0;
  - o_done exactly 21 cycles after start.
- Same pass with first_pass=0, last_pass=1: o_load_nbout pulses one cycle after each PRELOAD; both writes have o_n1_n2_to_nbout=1.
- num_out=1, num_in=3, i_stall high for 2 cycles on in_idx=1:
  - o_nbin_addr is held at 1 for 3 cycles;
  - o_acc_en shows exactly 3 one-cycle pulses;
  - o_done is 2 cycles later than with no stall.
- i_num_in=0: o_done is seen one cycle after start; no o_nbout_wen, o_sb_req or o_load_nbout.
- rst asserted during ISSUE of a 4x4 pass: the next cycle has all outputs 0 and state IDLE; no o_done; a fresh start runs normally.
- i_start pulsed again mid-pass: ignored; a single o_done with the original timing.

Source files
------------

// File: rtl/convpress_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | convpress_pkg                                                    |
// | Shared state encoding and default sizes for the node sequencer.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package convpress_pkg;

    localparam int DEF_ADDR_SZ  = 6;
    localparam int DEF_CNT_SZ   = 8;
    localparam int DEF_PIPE_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_LOAD    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/convpress_node_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | convpress_node_seq_if                                            |
// | Config/control bundle between layer controller and sequencer.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface convpress_node_seq_if
    import convpress_pkg::*;
#(
    parameter int ADDR_SZ = DEF_ADDR_SZ,
    parameter int CNT_SZ  = DEF_CNT_SZ
);
    logic                i_start;
    logic [CNT_SZ-1:0]   i_num_in;
    logic [ADDR_SZ-1:0]  i_num_out;
    logic                i_first_pass;
    logic                i_last_pass;
    logic                i_stall;
    logic                o_busy;
    logic                o_done;
    logic [ADDR_SZ-1:0]  o_nbin_addr;
    logic                o_sb_req;
    logic [ADDR_SZ-1:0]  o_nbout_addr;
    logic                o_nbout_wen;
    logic                o_load_nbout;
    logic                o_acc_clr;
    logic                o_acc_en;
    logic                o_n1_n2_to_nbout;

    modport slave (
        input  i_start, i_num_in, i_num_out, i_first_pass, i_last_pass, i_stall,
        output o_busy, o_done, o_nbin_addr, o_sb_req, o_nbout_addr, o_nbout_wen,
               o_load_nbout, o_acc_clr, o_acc_en, o_n1_n2_to_nbout
    );

    modport master (
        output i_start, i_num_in, i_num_out, i_first_pass, i_last_pass, i_stall,
        input  o_busy, o_done, o_nbin_addr, o_sb_req, o_nbout_addr, o_nbout_wen,
               o_load_nbout, o_acc_clr, o_acc_en, o_n1_n2_to_nbout
    );
endinterface
`default_nettype wire

// File: rtl/convpress_valid_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | convpress_valid_pipe                                             |
// | DEPTH-deep valid shift register tracking in-flight N0/N1 work.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module convpress_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_valid,
    output logic o_valid,
    output logic o_empty_next
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = i_valid;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], i_valid};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_valid = sr_q[DEPTH-1];
    // Flags emptiness of the value being loaded, so the last result retires
    // in the same cycle the sequencer decides to write it back.
    assign o_empty_next = ~|sr_d;
endmodule
`default_nettype wire

// File: rtl/convpress_node_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | convpress_node_seq                                               |
// | Per-row restore / issue / drain / write-back sequencer.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module convpress_node_seq
    import convpress_pkg::*;
#(
    parameter int ADDR_SZ  = DEF_ADDR_SZ,
    parameter int CNT_SZ   = DEF_CNT_SZ,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  wire                  clk,
    input  wire                  rst,
    convpress_node_seq_if.slave  bus
);
    seq_state_e          state_q, state_d;
    logic [CNT_SZ-1:0]   num_in_q, num_in_d;
    logic [CNT_SZ-1:0]   in_idx_q, in_idx_d;
    logic [ADDR_SZ-1:0]  num_out_q, num_out_d;
    logic [ADDR_SZ-1:0]  out_idx_q, out_idx_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                w_accept;
    logic                w_acc_en;
    logic                w_drained;

    assign w_accept = (state_q == ST_ISSUE) && !bus.i_stall;

    convpress_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (w_accept),
        .o_valid      (w_acc_en),
        .o_empty_next (w_drained)
    );

    assign bus.o_acc_en = w_acc_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            num_in_q  <= '0;
            in_idx_q  <= '0;
            num_out_q <= '0;
            out_idx_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_in_q  <= num_in_d;
            in_idx_q  <= in_idx_d;
            num_out_q <= num_out_d;
            out_idx_q <= out_idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        num_in_d  = num_in_q;
        in_idx_d  = in_idx_q;
        num_out_d = num_out_q;
        out_idx_d = out_idx_q;
        first_d   = first_q;
        last_d    = last_q;

        bus.o_busy           = (state_q != ST_IDLE);
        bus.o_done           = 1'b0;
        bus.o_nbin_addr      = '0;
        bus.o_sb_req         = 1'b0;
        bus.o_nbout_addr     = '0;
        bus.o_nbout_wen      = 1'b0;
        bus.o_load_nbout     = 1'b0;
        bus.o_acc_clr        = 1'b0;
        bus.o_n1_n2_to_nbout = (state_q != ST_IDLE) && last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    num_in_d  = bus.i_num_in;
                    num_out_d = bus.i_num_out;
                    first_d   = bus.i_first_pass;
                    last_d    = bus.i_last_pass;
                    out_idx_d = '0;
                    if ((bus.i_num_in == '0) || (bus.i_num_out == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PRELOAD;
                    end
                end
            end
            ST_PRELOAD: begin
                bus.o_nbout_addr = out_idx_q;
                state_d          = ST_LOAD;
            end
            ST_LOAD: begin
                bus.o_nbout_addr = out_idx_q;
                bus.o_load_nbout = !first_q;
                bus.o_acc_clr    = first_q;
                in_idx_d         = '0;
                state_d          = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.o_nbin_addr = ADDR_SZ'(in_idx_q);
                bus.o_sb_req    = 1'b1;
                if (!bus.i_stall) begin
                    in_idx_d = in_idx_q + CNT_SZ'(1);
                    if (in_idx_q == num_in_q - CNT_SZ'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.o_nbout_addr = out_idx_q;
                bus.o_nbout_wen  = 1'b1;
                if (out_idx_q == num_out_q - ADDR_SZ'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    out_idx_d = out_idx_q + ADDR_SZ'(1);
                    state_d   = ST_PRELOAD;
                end
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_convpress_node_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_convpress_node_seq                                            |
// | Scoreboard bench for the node sequencer.                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_convpress_node_seq;
    localparam int ADDR_SZ  = 6;
    localparam int CNT_SZ   = 8;
    localparam int PIPE_LAT = 3;

    typedef struct {
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errs = 0;
    int   acc_cnt = 0;
    int   hold1 = 0;
    int   stall_left = 0;

    int  q_nbin[$];
    ev_t q_wr[$];
    ev_t q_ld[$];
    int  q_done[$];

    convpress_node_seq_if #(.ADDR_SZ(ADDR_SZ), .CNT_SZ(CNT_SZ)) bus ();

    convpress_node_seq #(
        .ADDR_SZ  (ADDR_SZ),
        .CNT_SZ   (CNT_SZ),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_sb_req && !bus.i_stall) begin
                if (q_nbin.size() == 0) chk("nbin_extra", 1, 0);
                else chk("nbin_addr", 32'(bus.o_nbin_addr), q_nbin.pop_front());
            end
            if (bus.o_sb_req && bus.o_nbin_addr == 1) hold1++;
            if (bus.o_acc_en) acc_cnt++;
            if (bus.o_nbout_wen) begin
                if (q_wr.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    ev_t e;
                    e = q_wr.pop_front();
                    chk("wr_addr", 32'(bus.o_nbout_addr), e.a);
                    chk("wr_src", 32'(bus.o_n1_n2_to_nbout), e.b);
                end
            end
            if (bus.o_load_nbout || bus.o_acc_clr) begin
                if (q_ld.size() == 0) chk("ld_extra", 1, 0);
                else begin
                    ev_t e;
                    e = q_ld.pop_front();
                    chk("ld_kind", {30'd0, bus.o_load_nbout, bus.o_acc_clr}, e.a);
                    chk("ld_cyc", cyc, e.b);
                end
            end
            if (bus.o_done) begin
                if (q_done.size() == 0) chk("done_extra", 1, 0);
                else chk("done_cyc", cyc, q_done.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (stall_left > 0 && bus.o_sb_req && bus.o_nbin_addr == 1) begin
            bus.i_stall = 1'b1;
            stall_left--;
        end else begin
            bus.i_stall = 1'b0;
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {12'd0, bus.o_busy, bus.o_done, bus.o_nbin_addr, bus.o_sb_req,
                bus.o_nbout_addr, bus.o_nbout_wen, bus.o_load_nbout, bus.o_acc_clr,
                bus.o_acc_en, bus.o_n1_n2_to_nbout};
    endfunction

    task automatic run_pass(input int nout, input int nin, input bit fp, input bit lp,
                            input int nstall, input bit restart);
        int c0;
        int rowlen;
        int guard;
        rowlen     = 3 + nin + PIPE_LAT;
        acc_cnt    = 0;
        hold1      = 0;
        stall_left = nstall;
        bus.i_num_in     = CNT_SZ'(nin);
        bus.i_num_out    = ADDR_SZ'(nout);
        bus.i_first_pass = fp;
        bus.i_last_pass  = lp;
        bus.i_start      = 1'b1;
        c0 = cyc;
        if (nin != 0 && nout != 0) begin
            for (int r = 0; r < nout; r++) begin
                for (int i = 0; i < nin; i++) q_nbin.push_back(i);
                q_wr.push_back('{a: r, b: int'(lp)});
                q_ld.push_back('{a: (fp ? 1 : 2), b: c0 + 2 + r * rowlen});
            end
            q_done.push_back(c0 + 1 + nout * rowlen + nstall);
        end else begin
            q_done.push_back(c0 + 1);
        end
        step();
        bus.i_start = 1'b0;
        chk("busy_on", 32'(bus.o_busy), 1);
        guard = 0;
        while (q_done.size() != 0 && guard < 2000) begin
            if (restart && guard == 5) begin
                bus.i_start  = 1'b1;
                bus.i_num_in = CNT_SZ'(7);
            end else begin
                bus.i_start = 1'b0;
            end
            step();
            guard++;
        end
        bus.i_start = 1'b0;
        chk("done_timeout", q_done.size(), 0);
        step();
        step();
        chk("acc_en_cnt", acc_cnt, nout * nin);
        chk("nbin_left", q_nbin.size(), 0);
        chk("wr_left", q_wr.size(), 0);
        chk("ld_left", q_ld.size(), 0);
        chk("idle_busy", 32'(bus.o_busy), 0);
        chk("idle_n1n2", 32'(bus.o_n1_n2_to_nbout), 0);
    endtask

    initial begin
        int guard;
        bus.i_start      = 1'b0;
        bus.i_num_in     = '0;
        bus.i_num_out    = '0;
        bus.i_first_pass = 1'b0;
        bus.i_last_pass  = 1'b0;
        bus.i_stall      = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_outs", outs_vec(), 0);

        run_pass(2, 4, 1'b1, 1'b0, 0, 1'b0);
        run_pass(2, 4, 1'b0, 1'b1, 0, 1'b0);
        run_pass(1, 3, 1'b1, 1'b0, 2, 1'b0);
        chk("stall_hold", hold1, 3);
        run_pass(3, 0, 1'b1, 1'b1, 0, 1'b0);
        run_pass(0, 5, 1'b0, 1'b0, 0, 1'b0);

        // Abort a 4x4 pass during ISSUE.
        for (int i = 0; i < 4; i++) q_nbin.push_back(i);
        bus.i_num_in     = CNT_SZ'(4);
        bus.i_num_out    = ADDR_SZ'(4);
        bus.i_first_pass = 1'b1;
        bus.i_last_pass  = 1'b1;
        bus.i_start      = 1'b1;
        q_ld.push_back('{a: 1, b: cyc + 2});
        step();
        bus.i_start = 1'b0;
        guard = 0;
        while (!(bus.o_sb_req && bus.o_nbin_addr == 2) && guard < 50) begin
            step();
            guard++;
        end
        chk("rst_reach_issue", 32'(bus.o_sb_req), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outs", outs_vec(), 0);
        q_nbin.delete();
        q_wr.delete();
        q_ld.delete();
        q_done.delete();
        acc_cnt = 0;
        repeat (40) step();
        chk("rst_no_acc", acc_cnt, 0);
        run_pass(1, 2, 1'b1, 1'b1, 0, 1'b0);

        run_pass(2, 4, 1'b1, 1'b1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
